// File: rtl/hit_readout.sv
// hit_readout: streams the stored hits of one SSID from the HNM/HCM/HIM block-memory hit store
// Optional macro READOUT_SSID_TAG_EN adds output hitSSIDOut carrying the captured SSID with each response.
module hit_readout #(
   parameter int SSIDBITS         = 10,
   parameter int COLINDEXBITS_HNM = 5,
   parameter int ROWINDEXBITS_HNM = 5,
   parameter int HITINFOBITS      = 8,
   parameter int MAXHITNBITS      = 3,
   parameter int ROWINDEXBITS_HIM = 8,
   parameter int MAXHITS          = 4
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  storageReadReady,
   input  logic                                  readRequest,
   input  logic [SSIDBITS-1:0]                   readSSID,
   output logic                                  readAck,
   output logic                                  busy,
   output logic [ROWINDEXBITS_HNM-1:0]           hnmRdAddr,
   input  logic [2**COLINDEXBITS_HNM-1:0]        hnmRdData,
   output logic [SSIDBITS-1:0]                   hcmRdAddr,
   input  logic [ROWINDEXBITS_HIM+MAXHITNBITS-1:0] hcmRdData,
   output logic [ROWINDEXBITS_HIM-1:0]           himRdAddr,
   input  logic [MAXHITS*HITINFOBITS-1:0]        himRdData,
   output logic                                  hitValid,
   input  logic                                  hitReady,
   output logic [HITINFOBITS-1:0]                hitInfoOut,
   output logic                                  hitLast,
   output logic                                  emptyValid,
`ifdef READOUT_SSID_TAG_EN
   output logic [SSIDBITS-1:0]                   hitSSIDOut,
`endif
   output logic                                  countError
);

   localparam logic [MAXHITNBITS-1:0] MAXN = MAXHITNBITS'(MAXHITS);
   localparam logic [MAXHITNBITS-1:0] ONE  = MAXHITNBITS'(1);

   typedef enum logic [3:0] {
      IDLE, HNM_ADDR, HNM_WAIT, HNM_CHK, HCM_ADDR, HCM_WAIT, HCM_CHK,
      HIM_ADDR, HIM_WAIT, HIM_CHK, STREAM, EMPTY
   } state_t;

   state_t                         state_q, state_d;
   logic [SSIDBITS-1:0]            ssid_q, ssid_d;
   logic [ROWINDEXBITS_HNM-1:0]    hnm_addr_q, hnm_addr_d;
   logic [SSIDBITS-1:0]            hcm_addr_q, hcm_addr_d;
   logic [ROWINDEXBITS_HIM-1:0]    him_addr_q, him_addr_d;
   logic [MAXHITNBITS-1:0]         idx_q, idx_d;
   logic [MAXHITS*HITINFOBITS-1:0] word_q, word_d;
   logic                           err_q, err_d;
   logic [MAXHITNBITS-1:0]         hit_n, n_clamp;

   assign hit_n   = hcmRdData[MAXHITNBITS-1:0];
   assign n_clamp = (hit_n > MAXN) ? MAXN : hit_n;

   assign busy       = state_q != IDLE;
   assign hitValid   = state_q == STREAM;
   assign hitLast    = hitValid && idx_q == '0;
   assign hitInfoOut = hitValid ? word_q[idx_q*HITINFOBITS +: HITINFOBITS] : '0;
   assign emptyValid = state_q == EMPTY;
   assign hnmRdAddr  = hnm_addr_q;
   assign hcmRdAddr  = hcm_addr_q;
   assign himRdAddr  = him_addr_q;
   assign countError = err_q;
`ifdef READOUT_SSID_TAG_EN
   assign hitSSIDOut = (hitValid || emptyValid) ? ssid_q : '0;
`endif

   // Next-state: walk HNM -> HCM -> HIM with two-cycle reads, then stream oldest record first
   always_comb begin
      state_d    = state_q;
      ssid_d     = ssid_q;
      hnm_addr_d = hnm_addr_q;
      hcm_addr_d = hcm_addr_q;
      him_addr_d = him_addr_q;
      idx_d      = idx_q;
      word_d     = word_q;
      err_d      = err_q;
      readAck    = 1'b0;
      case (state_q)
         IDLE:
            if (readRequest && storageReadReady && !reset) begin
               readAck = 1'b1;
               ssid_d  = readSSID;
               state_d = HNM_ADDR;
            end
         HNM_ADDR: begin
            hnm_addr_d = ssid_q[COLINDEXBITS_HNM +: ROWINDEXBITS_HNM];
            state_d    = HNM_WAIT;
         end
         HNM_WAIT: state_d = HNM_CHK;
         HNM_CHK:  state_d = hnmRdData[ssid_q[COLINDEXBITS_HNM-1:0]] ? HCM_ADDR : EMPTY;
         HCM_ADDR: begin
            hcm_addr_d = ssid_q;
            state_d    = HCM_WAIT;
         end
         HCM_WAIT: state_d = HCM_CHK;
         HCM_CHK: begin
            him_addr_d = hcmRdData[MAXHITNBITS +: ROWINDEXBITS_HIM];
            idx_d      = n_clamp - ONE;
            err_d      = err_q || hit_n == '0 || hit_n > MAXN;
            state_d    = (hit_n == '0) ? EMPTY : HIM_ADDR;
         end
         HIM_ADDR: state_d = HIM_WAIT;
         HIM_WAIT: state_d = HIM_CHK;
         HIM_CHK: begin
            word_d  = himRdData;
            state_d = STREAM;
         end
         STREAM:
            if (hitReady) begin
               idx_d   = idx_q - ONE;
               state_d = (idx_q == '0) ? IDLE : STREAM;
            end
         EMPTY:    state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // State and datapath registers; async reset drops any query in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ssid_q     <= '0;
         hnm_addr_q <= '0;
         hcm_addr_q <= '0;
         him_addr_q <= '0;
         idx_q      <= '0;
         word_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ssid_q     <= ssid_d;
         hnm_addr_q <= hnm_addr_d;
         hcm_addr_q <= hcm_addr_d;
         him_addr_q <= him_addr_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_hit_readout.sv
// tb_hit_readout: directed checks of hit_readout against a registered-read model of the hit store
module tb_hit_readout;

   logic        clock = 1'b0;
   logic        reset;
   logic        storageReadReady, readRequest, hitReady;
   logic [9:0]  readSSID;
   logic        readAck, busy, hitValid, hitLast, emptyValid, countError;
   logic [4:0]  hnmRdAddr;
   logic [31:0] hnmRdData;
   logic [9:0]  hcmRdAddr;
   logic [10:0] hcmRdData;
   logic [7:0]  himRdAddr;
   logic [31:0] himRdData;
   logic [7:0]  hitInfoOut;
`ifdef READOUT_SSID_TAG_EN
   logic [9:0]  hitSSIDOut;
`endif

   logic [31:0] hnm_mem [32];
   logic [10:0] hcm_mem [1024];
   logic [31:0] him_mem [256];

   int n_checks = 0;
   int n_err    = 0;
   int ack_wait = 0;

   hit_readout dut (
      .clock(clock), .reset(reset), .storageReadReady(storageReadReady),
      .readRequest(readRequest), .readSSID(readSSID), .readAck(readAck), .busy(busy),
      .hnmRdAddr(hnmRdAddr), .hnmRdData(hnmRdData),
      .hcmRdAddr(hcmRdAddr), .hcmRdData(hcmRdData),
      .himRdAddr(himRdAddr), .himRdData(himRdData),
      .hitValid(hitValid), .hitReady(hitReady), .hitInfoOut(hitInfoOut), .hitLast(hitLast),
      .emptyValid(emptyValid),
`ifdef READOUT_SSID_TAG_EN
      .hitSSIDOut(hitSSIDOut),
`endif
      .countError(countError)
   );

   always #5 clock = ~clock;

   // Block memories with one-cycle registered read
   always @(posedge clock) begin
      hnmRdData <= hnm_mem[hnmRdAddr];
      hcmRdData <= hcm_mem[hcmRdAddr];
      himRdData <= him_mem[himRdAddr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Raise a query at a negedge; returns at the negedge one cycle after readAck
   task automatic query(input logic [9:0] ssid);
      int w = 0;
      readSSID    = ssid;
      readRequest = 1'b1;
      #1;
      while (!readAck && w < 20) begin
         @(negedge clock);
         #1;
         w++;
      end
      ack_wait = w;
      check("ack", readAck, 1);
      @(negedge clock);
      check("ack_pulse", readAck, 0);
      check("busy_after_ack", busy, 1);
      readRequest = 1'b0;
   endtask

   task automatic run_empty(input logic [9:0] ssid, input int lat);
      query(ssid);
      repeat (lat - 2) @(negedge clock);
      check("empty_early", emptyValid, 0);
      check("hnm_addr", hnmRdAddr, 32'(ssid[9:5]));
`ifdef READOUT_SSID_TAG_EN
      check("tag_idle", hitSSIDOut, 0);
`endif
      @(negedge clock);
      check("empty", emptyValid, 1);
      check("empty_nohit", hitValid, 0);
`ifdef READOUT_SSID_TAG_EN
      check("tag_empty", hitSSIDOut, 32'(ssid));
`endif
      @(negedge clock);
      check("empty_pulse", emptyValid, 0);
      check("empty_busy", busy, 0);
   endtask

   // Expect n records, record n-1 first; stall ready at record stall_pos; return early after stop records
   task automatic run_hits(input logic [9:0] ssid, input logic [31:0] word, input int n,
                           input logic [7:0] him_row, input int stall_pos, input int stall_len,
                           input int stop);
      logic [7:0] rec;
      query(ssid);
      repeat (8) @(negedge clock);
      check("hit_latency", hitValid, 0);
      check("him_addr", himRdAddr, 32'(him_row));
      @(negedge clock);
      for (int k = 0; k < n; k++) begin
         if (k == stop) return;
         rec = word[(n-1-k)*8 +: 8];
         if (k == stall_pos) begin
            hitReady = 1'b0;
            repeat (stall_len) begin
               check("stall_valid", hitValid, 1);
               check("stall_info", hitInfoOut, 32'(rec));
               check("stall_last", hitLast, 32'(k == n-1));
               @(negedge clock);
            end
            hitReady = 1'b1;
         end
         check("hit_valid", hitValid, 1);
         check("hit_info", hitInfoOut, 32'(rec));
         check("hit_last", hitLast, 32'(k == n-1));
`ifdef READOUT_SSID_TAG_EN
         check("tag_hit", hitSSIDOut, 32'(ssid));
`endif
         @(negedge clock);
      end
      check("stream_done", hitValid, 0);
      check("stream_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) hnm_mem[i] = '0;
      for (int i = 0; i < 1024; i++) hcm_mem[i] = '0;
      for (int i = 0; i < 256; i++) him_mem[i] = '0;
      hnm_mem[2]     = 32'h0000_00E0;
      hcm_mem[10'h045] = {8'h07, 3'd3};
      hcm_mem[10'h046] = {8'h10, 3'd0};
      hcm_mem[10'h047] = {8'h11, 3'd6};
      him_mem[8'h07] = 32'hDDCC_BBAA;
      him_mem[8'h11] = 32'h4433_2211;
      reset = 1'b1;
      storageReadReady = 1'b1;
      readRequest = 1'b1;
      hitReady = 1'b1;
      readSSID = 10'h045;
      repeat (3) @(negedge clock);
      check("rst_ack", readAck, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", hitValid, 0);
      check("rst_empty", emptyValid, 0);
      check("rst_err", countError, 0);
      check("rst_addrs", {hnmRdAddr, hcmRdAddr, himRdAddr}, 0);
      readRequest = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      // 1: unhit SSID
      run_empty(10'h123, 4);
      // 2: three hits, oldest first
      run_hits(10'h045, 32'hDDCC_BBAA, 3, 8'h07, -1, 0, 99);
      // 3: stall on second record
      run_hits(10'h045, 32'hDDCC_BBAA, 3, 8'h07, 1, 5, 99);
      // 4: store not ready blocks the ack
      storageReadReady = 1'b0;
      readSSID = 10'h123;
      readRequest = 1'b1;
      repeat (8) begin
         #1;
         check("ack_blocked", readAck, 0);
         check("busy_blocked", busy, 0);
         @(negedge clock);
      end
      storageReadReady = 1'b1;
      run_empty(10'h123, 4);
      check("ack_first", ack_wait, 0);
      // 5: count errors
      check("err_clean", countError, 0);
      run_empty(10'h046, 7);
      check("err_zero", countError, 1);
      run_hits(10'h047, 32'h4433_2211, 4, 8'h11, -1, 0, 99);
      check("err_sticky", countError, 1);
      // 6: reset mid-stream
      run_hits(10'h045, 32'hDDCC_BBAA, 3, 8'h07, -1, 0, 1);
      check("pre_rst_info", hitInfoOut, 32'hBB);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", hitValid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ack", readAck, 0);
      check("mid_rst_addrs", {hnmRdAddr, hcmRdAddr, himRdAddr}, 0);
      check("mid_rst_err", countError, 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      run_hits(10'h045, 32'hDDCC_BBAA, 3, 8'h07, -1, 0, 99);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
